// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: the fetch->decode record and the fetch FSM states.
package fetch_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t pcplus4;
        word_t raw_instr;
        logic  exception_instr;
        logic  i_tlb_invalid;
        logic  i_tlb_modified;
        logic  i_tlb_refill;
    } fetch_data_t;

    localparam int FETCH_DATA_W = $bits(fetch_data_t);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_issue_unit.sv
// Fetch issue unit: owns the fetch PC, drives a single-outstanding ibus request and hands records to decode.
// Optional macro FETCH_TLB_EXC_EN turns itlb flags into fetch exceptions and copies them into records.
module fetch_issue_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    output logic                    ireq_valid,
    output logic [31:0]             ireq_addr,
    input  logic                    iresp_addr_ok,
    input  logic                    iresp_data_ok,
    input  logic [31:0]             iresp_data,
    input  logic                    itlb_invalid,
    input  logic                    itlb_modified,
    input  logic                    itlb_refill,
    output logic                    out_valid,
    output logic [FETCH_DATA_W-1:0] out_data,
    input  logic                    out_ready
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    logic         out_valid_q, out_valid_d;
    fetch_data_t  rec_q, rec_d;

    word_t        pcplus4;
    logic         fault;
    logic [2:0]   tlb_flags;
    logic         tlb_exc;

`ifdef FETCH_TLB_EXC_EN
    assign tlb_flags = {itlb_invalid, itlb_modified, itlb_refill};
    assign tlb_exc   = |tlb_flags;
`else
    logic unused_tlb;
    assign unused_tlb = itlb_invalid ^ itlb_modified ^ itlb_refill;
    assign tlb_flags  = 3'b000;
    assign tlb_exc    = 1'b0;
`endif

    assign pcplus4 = pc_q + 32'd4;
    assign fault   = (pc_q[1:0] != 2'b00);

    // Request only from registered state/pc; resetn gate keeps the bus quiet while held in reset.
    assign ireq_valid = resetn && (state_q == REQ) && !fault && !tlb_exc;
    assign ireq_addr  = pc_q;
    assign out_valid  = out_valid_q;
    assign out_data   = rec_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        rec_d       = rec_q;

        case (state_q)
            REQ: begin
                // A redirect beats a local fault: the faulting pc is no longer architectural.
                if (redirect_valid) begin
                    if (ireq_valid && iresp_addr_ok) begin
                        state_d = DROP;
                    end
                end else if (fault) begin
                    rec_d                 = '0;
                    rec_d.pcplus4         = pcplus4;
                    rec_d.exception_instr = 1'b1;
                    out_valid_d           = 1'b1;
                    state_d               = HOLD;
                end else if (tlb_exc) begin
                    rec_d                = '0;
                    rec_d.pcplus4        = pcplus4;
                    rec_d.i_tlb_invalid  = tlb_flags[2];
                    rec_d.i_tlb_modified = tlb_flags[1];
                    rec_d.i_tlb_refill   = tlb_flags[0];
                    out_valid_d          = 1'b1;
                    state_d              = HOLD;
                end else if (iresp_addr_ok) begin
                    rec_d                = '0;
                    rec_d.pcplus4        = pcplus4;
                    rec_d.i_tlb_invalid  = tlb_flags[2];
                    rec_d.i_tlb_modified = tlb_flags[1];
                    rec_d.i_tlb_refill   = tlb_flags[0];
                    state_d              = WAIT;
                end
            end
            WAIT: begin
                if (iresp_data_ok) begin
                    if (redirect_valid) begin
                        state_d = REQ;
                    end else begin
                        rec_d.raw_instr = iresp_data;
                        out_valid_d     = 1'b1;
                        state_d         = HOLD;
                    end
                end else if (redirect_valid) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (iresp_data_ok) begin
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    out_valid_d = 1'b0;
                    state_d     = REQ;
                end else if (out_ready) begin
                    pc_d        = pcplus4;
                    out_valid_d = 1'b0;
                    state_d     = REQ;
                end
            end
            default: state_d = REQ;
        endcase

        if (redirect_valid) begin
            pc_d = redirect_pc;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= REQ;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            rec_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            rec_q       <= rec_d;
        end
    end

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Directed bench for fetch_issue_unit; expected records go into a queue checked by a separate monitor.
module tb_fetch_issue_unit;
    import fetch_pkg::*;

    logic                    clk;
    logic                    resetn;
    logic                    redirect_valid;
    logic [31:0]             redirect_pc;
    logic                    ireq_valid;
    logic [31:0]             ireq_addr;
    logic                    iresp_addr_ok;
    logic                    iresp_data_ok;
    logic [31:0]             iresp_data;
    logic                    itlb_invalid;
    logic                    itlb_modified;
    logic                    itlb_refill;
    logic                    out_valid;
    logic [FETCH_DATA_W-1:0] out_data;
    logic                    out_ready;

    int tests = 0;
    int fails = 0;
    fetch_data_t exp_q[$];

    fetch_issue_unit #(.RESET_PC(32'hbfc0_0000)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_addr_ok  (iresp_addr_ok),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .itlb_invalid   (itlb_invalid),
        .itlb_modified  (itlb_modified),
        .itlb_refill    (itlb_refill),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %h", name, act);
        end
    endtask

    function automatic fetch_data_t mk(input logic [31:0] p4, input logic [31:0] raw,
                                       input logic exc, input logic inv, input logic mdf,
                                       input logic rfl);
        fetch_data_t r;
        r.pcplus4         = p4;
        r.raw_instr       = raw;
        r.exception_instr = exc;
        r.i_tlb_invalid   = inv;
        r.i_tlb_modified  = mdf;
        r.i_tlb_refill    = rfl;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops on every accepted record and checks HOLD stability.
    initial begin
        logic        stall_prev;
        fetch_data_t stall_data;
        fetch_data_t e;
        stall_prev = 1'b0;
        stall_data = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("hold_stable_valid", 68'(out_valid), 68'(1'b1));
                    chk("hold_stable_data", out_data, stall_data);
                end
                stall_prev = out_valid && !out_ready && !redirect_valid;
                stall_data = out_data;
                if (out_valid && out_ready && !redirect_valid) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_record: got %h expected none", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("record", out_data, e);
                    end
                end
            end
        end
    end

    initial begin
        resetn         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        iresp_addr_ok  = 1'b0;
        iresp_data_ok  = 1'b0;
        iresp_data     = '0;
        itlb_invalid   = 1'b0;
        itlb_modified  = 1'b0;
        itlb_refill    = 1'b0;
        out_ready      = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ireq_valid", 68'(ireq_valid), 68'(1'b0));
        chk("rst_out_valid", 68'(out_valid), 68'(1'b0));
        chk("rst_out_data", out_data, 68'(0));
        chk("rst_ireq_addr", 68'(ireq_addr), 68'(32'hbfc0_0000));
        resetn = 1'b1;

        // Basic fetch: addr_ok at T, data_ok at T+2, record at T+3
        iresp_addr_ok = 1'b1;
        out_ready     = 1'b1;
        #1;
        chk("t1_ireq_valid", 68'(ireq_valid), 68'(1'b1));
        chk("t1_ireq_addr", 68'(ireq_addr), 68'(32'hbfc0_0000));
        tick();
        iresp_addr_ok = 1'b0;
        chk("t1_wait_no_req", 68'(ireq_valid), 68'(1'b0));
        tick();
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h2408_0001;
        exp_q.push_back(mk(32'hbfc0_0004, 32'h2408_0001, 1'b0, 1'b0, 1'b0, 1'b0));
        chk("t1_no_early_valid", 68'(out_valid), 68'(1'b0));
        tick();
        iresp_data_ok = 1'b0;
        chk("t1_latency_valid", 68'(out_valid), 68'(1'b1));
        tick();
        chk("t1_next_addr", 68'(ireq_addr), 68'(32'hbfc0_0004));
        chk("t1_next_valid", 68'(ireq_valid), 68'(1'b1));

        // Back-pressure in HOLD for 5 cycles
        iresp_addr_ok = 1'b1;
        out_ready     = 1'b0;
        tick();
        iresp_addr_ok = 1'b0;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h3c01_1234;
        exp_q.push_back(mk(32'hbfc0_0008, 32'h3c01_1234, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        iresp_data_ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", 68'(out_valid), 68'(1'b1));
            chk("t2_hold_no_req", 68'(ireq_valid), 68'(1'b0));
            chk("t2_hold_data", out_data,
                mk(32'hbfc0_0008, 32'h3c01_1234, 1'b0, 1'b0, 1'b0, 1'b0));
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("t2_next_addr", 68'(ireq_addr), 68'(32'hbfc0_0008));

        // Redirect in WAIT: late data is dropped
        iresp_addr_ok = 1'b1;
        tick();
        iresp_addr_ok  = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        chk("t3_drop_no_req", 68'(ireq_valid), 68'(1'b0));
        tick();
        tick();
        iresp_data_ok = 1'b1;
        iresp_data    = 32'hdead_beef;
        tick();
        iresp_data_ok = 1'b0;
        chk("t3_no_record", 68'(out_valid), 68'(1'b0));
        chk("t3_req_valid", 68'(ireq_valid), 68'(1'b1));
        chk("t3_req_addr", 68'(ireq_addr), 68'(32'h8000_0100));

        // Misaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        tick();
        redirect_valid = 1'b0;
        chk("t4_fault_no_req", 68'(ireq_valid), 68'(1'b0));
        chk("t4_fault_addr", 68'(ireq_addr), 68'(32'h8000_0102));
        exp_q.push_back(mk(32'h8000_0106, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0));
        tick();
        chk("t4_fault_valid", 68'(out_valid), 68'(1'b1));
        tick();
        chk("t4_still_faulting", 68'(ireq_valid), 68'(1'b0));
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        tick();
        redirect_valid = 1'b0;
        chk("t4_redirect_beats_fault", 68'(out_valid), 68'(1'b0));
        chk("t4_req_valid", 68'(ireq_valid), 68'(1'b1));

        // Redirect and data_ok together in WAIT
        iresp_addr_ok = 1'b1;
        tick();
        iresp_addr_ok  = 1'b0;
        iresp_data_ok  = 1'b1;
        iresp_data     = 32'h1111_1111;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        tick();
        iresp_data_ok  = 1'b0;
        redirect_valid = 1'b0;
        chk("t5_no_record", 68'(out_valid), 68'(1'b0));
        chk("t5_req_valid", 68'(ireq_valid), 68'(1'b1));
        chk("t5_req_addr", 68'(ireq_addr), 68'(32'h8000_0300));
        tick();
        chk("t5_still_no_record", 68'(out_valid), 68'(1'b0));

        // PC wrap at the top of the address space, k=1 response
        redirect_valid = 1'b1;
        redirect_pc    = 32'hffff_fffc;
        tick();
        redirect_valid = 1'b0;
        iresp_addr_ok  = 1'b1;
        chk("t6_top_addr", 68'(ireq_addr), 68'(32'hffff_fffc));
        tick();
        iresp_addr_ok = 1'b0;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h0085_1021;
        exp_q.push_back(mk(32'h0000_0000, 32'h0085_1021, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        iresp_data_ok = 1'b0;
        tick();
        chk("t6_wrap_addr", 68'(ireq_addr), 68'(32'h0000_0000));
        chk("t6_wrap_valid", 68'(ireq_valid), 68'(1'b1));

        // itlb refill at 0x0040_0000
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0000;
        tick();
        redirect_valid = 1'b0;
        itlb_refill    = 1'b1;
        #1;
`ifdef FETCH_TLB_EXC_EN
        chk("t7_tlb_no_req", 68'(ireq_valid), 68'(1'b0));
        exp_q.push_back(mk(32'h0040_0004, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1));
        tick();
        itlb_refill = 1'b0;
        chk("t7_tlb_valid", 68'(out_valid), 68'(1'b1));
        tick();
        chk("t7_next_addr", 68'(ireq_addr), 68'(32'h0040_0004));
`else
        chk("t7_tlb_ignored_req", 68'(ireq_valid), 68'(1'b1));
        iresp_addr_ok = 1'b1;
        tick();
        iresp_addr_ok = 1'b0;
        itlb_refill   = 1'b0;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h2402_0004;
        exp_q.push_back(mk(32'h0040_0004, 32'h2402_0004, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        iresp_data_ok = 1'b0;
        tick();
        chk("t7_next_addr", 68'(ireq_addr), 68'(32'h0040_0004));
`endif

        // Reset while a response is outstanding
        iresp_addr_ok = 1'b1;
        tick();
        iresp_addr_ok = 1'b0;
        resetn        = 1'b0;
        #1;
        chk("t8_rst_ireq_valid", 68'(ireq_valid), 68'(1'b0));
        chk("t8_rst_out_valid", 68'(out_valid), 68'(1'b0));
        chk("t8_rst_addr", 68'(ireq_addr), 68'(32'hbfc0_0000));
        tick();
        resetn        = 1'b1;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'haaaa_aaaa;
        tick();
        iresp_data_ok = 1'b0;
        chk("t8_stale_ignored", 68'(out_valid), 68'(1'b0));
        chk("t8_req_valid", 68'(ireq_valid), 68'(1'b1));
        chk("t8_req_addr", 68'(ireq_addr), 68'(32'hbfc0_0000));

        repeat (3) tick();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL records_drained: got %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
